// File: rtl/core_fpu_fcsr.sv
// RV32F floating-point CSR: sticky fflags, frm, dirty tracking and rounding-mode resolve.
// Optional macro FCSR_READ_BYPASS_EN forwards same-cycle FPU flags into CSR reads and RS/RC.
module core_fpu_fcsr (
    input  logic        clk,
    input  logic        rst,
    input  logic        fpu_valid_i,
    input  logic [4:0]  fpu_fflags_i,
    input  logic [2:0]  instr_rm_i,
    output logic [2:0]  rm_o,
    output logic        rm_illegal_o,
    input  logic [1:0]  csr_op_i,
    input  logic [11:0] csr_addr_i,
    input  logic [31:0] csr_wdata_i,
    output logic [31:0] csr_rdata_o,
    output logic        csr_hit_o,
    output logic [4:0]  fflags_o,
    output logic [2:0]  frm_o,
    output logic        dirty_o,
    input  logic        dirty_clr_i
);

    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_e;

    localparam logic [11:0] ADDR_FFLAGS = 12'h001;
    localparam logic [11:0] ADDR_FRM    = 12'h002;
    localparam logic [11:0] ADDR_FCSR   = 12'h003;

    logic [4:0] fflags_q, fflags_d;
    logic [2:0] frm_q, frm_d;
    logic       dirty_q, dirty_d;

    csr_op_e    csr_op;
    logic       sel_fflags, sel_frm;
    logic [4:0] fflags_opnd, fflags_old, fflags_csr;
    logic [2:0] frm_opnd, frm_csr;
    logic [4:0] frm_wide;
    logic       fflags_wr, frm_wr, fpu_sets;

    function automatic logic [4:0] csr_apply(input csr_op_e op, input logic [4:0] old,
                                             input logic [4:0] opnd);
        case (op)
            CSR_RW:  csr_apply = opnd;
            CSR_RS:  csr_apply = old | opnd;
            CSR_RC:  csr_apply = old & ~opnd;
            default: csr_apply = old;
        endcase
    endfunction

    assign csr_op = csr_op_e'(csr_op_i);

    always_comb begin
        sel_fflags  = (csr_addr_i == ADDR_FFLAGS) || (csr_addr_i == ADDR_FCSR);
        sel_frm     = (csr_addr_i == ADDR_FRM)    || (csr_addr_i == ADDR_FCSR);
        fflags_opnd = csr_wdata_i[4:0];
        frm_opnd    = (csr_addr_i == ADDR_FCSR) ? csr_wdata_i[7:5] : csr_wdata_i[2:0];
    end

    assign csr_hit_o = sel_fflags | sel_frm;

`ifdef FCSR_READ_BYPASS_EN
    assign fflags_old = fpu_valid_i ? (fflags_q | fpu_fflags_i) : fflags_q;
`else
    assign fflags_old = fflags_q;
`endif

    always_comb begin
        csr_rdata_o = '0;
        case (csr_addr_i)
            ADDR_FFLAGS: csr_rdata_o = {27'b0, fflags_old};
            ADDR_FRM:    csr_rdata_o = {29'b0, frm_q};
            ADDR_FCSR:   csr_rdata_o = {24'b0, frm_q, fflags_old};
            default:     csr_rdata_o = '0;
        endcase
    end

    // The retiring FPU op is younger than the CSR op, so its flags are ORed after the CSR result.
    always_comb begin
        fflags_csr = fflags_old;
        frm_csr    = frm_q;
        frm_wide   = '0;
        fflags_wr  = 1'b0;
        frm_wr     = 1'b0;
        if (csr_op != CSR_NONE) begin
            if (sel_fflags) begin
                fflags_csr = csr_apply(csr_op, fflags_old, fflags_opnd);
                fflags_wr  = (csr_op == CSR_RW) || (fflags_opnd != '0);
            end
            if (sel_frm) begin
                frm_wide = csr_apply(csr_op, {2'b0, frm_q}, {2'b0, frm_opnd});
                frm_csr  = frm_wide[2:0];
                frm_wr   = (csr_op == CSR_RW) || (frm_opnd != '0);
            end
        end
        fpu_sets = fpu_valid_i && (fpu_fflags_i != '0);
        fflags_d = fpu_valid_i ? (fflags_csr | fpu_fflags_i) : fflags_csr;
        frm_d    = frm_csr;
        if (fflags_wr || frm_wr || fpu_sets) begin
            dirty_d = 1'b1;
        end else if (dirty_clr_i) begin
            dirty_d = 1'b0;
        end else begin
            dirty_d = dirty_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fflags_q <= '0;
            frm_q    <= '0;
            dirty_q  <= 1'b0;
        end else begin
            fflags_q <= fflags_d;
            frm_q    <= frm_d;
            dirty_q  <= dirty_d;
        end
    end

    // Dynamic mode uses the registered frm; a same-cycle frm write is not forwarded.
    assign rm_o         = (instr_rm_i == 3'b111) ? frm_q : instr_rm_i;
    assign rm_illegal_o = (rm_o >= 3'd5);

    assign fflags_o = fflags_q;
    assign frm_o    = frm_q;
    assign dirty_o  = dirty_q;

endmodule

// File: tb/tb_core_fpu_fcsr.sv
// Self-checking bench for core_fpu_fcsr: vector table, directed corner sequences, random vs. model.
module tb_core_fpu_fcsr;

`ifdef FCSR_READ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        fpu_valid_i;
    logic [4:0]  fpu_fflags_i;
    logic [2:0]  instr_rm_i;
    logic [2:0]  rm_o;
    logic        rm_illegal_o;
    logic [1:0]  csr_op_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i;
    logic [31:0] csr_rdata_o;
    logic        csr_hit_o;
    logic [4:0]  fflags_o;
    logic [2:0]  frm_o;
    logic        dirty_o;
    logic        dirty_clr_i;

    int errors = 0;
    int checks = 0;

    int unsigned m_ff = 0;
    int unsigned m_frm = 0;
    int unsigned m_dirty = 0;

    core_fpu_fcsr dut (
        .clk          (clk),
        .rst          (rst),
        .fpu_valid_i  (fpu_valid_i),
        .fpu_fflags_i (fpu_fflags_i),
        .instr_rm_i   (instr_rm_i),
        .rm_o         (rm_o),
        .rm_illegal_o (rm_illegal_o),
        .csr_op_i     (csr_op_i),
        .csr_addr_i   (csr_addr_i),
        .csr_wdata_i  (csr_wdata_i),
        .csr_rdata_o  (csr_rdata_o),
        .csr_hit_o    (csr_hit_o),
        .fflags_o     (fflags_o),
        .frm_o        (frm_o),
        .dirty_o      (dirty_o),
        .dirty_clr_i  (dirty_clr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        fv;
        logic [4:0]  ff;
        logic [2:0]  rm;
        logic        clr;
        logic [2:0]  exp_rm;
        logic        exp_ill;
        logic [4:0]  exp_ff;
        logic [2:0]  exp_frm;
        logic        exp_dirty;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wdata,
                         input logic fv, input logic [4:0] ff, input logic [2:0] rm,
                         input logic clr);
        csr_op_i     = op;
        csr_addr_i   = addr;
        csr_wdata_i  = wdata;
        fpu_valid_i  = fv;
        fpu_fflags_i = ff;
        instr_rm_i   = rm;
        dirty_clr_i  = clr;
    endtask

    // Flags as a reader sees them this cycle.
    function automatic int unsigned view_ff();
        int unsigned v = m_ff;
        if (BYP && fpu_valid_i) v = v | int'(fpu_fflags_i);
        return v;
    endfunction

    function automatic int unsigned exp_read();
        case (int'(csr_addr_i))
            1:       return view_ff();
            2:       return m_frm;
            3:       return m_frm * 32 + view_ff();
            default: return 0;
        endcase
    endfunction

    function automatic int unsigned exp_rm();
        return (instr_rm_i == 3'b111) ? m_frm : int'(instr_rm_i);
    endfunction

    // Model treats fcsr as one 8-bit value {frm,fflags}; each address writes a masked slice of it.
    task automatic model_step();
        int unsigned old8, opnd, mask, new8, a, op;
        bit set;
        if (rst) begin
            m_ff = 0; m_frm = 0; m_dirty = 0;
            return;
        end
        set  = 0;
        a    = int'(csr_addr_i);
        op   = int'(csr_op_i);
        old8 = m_frm * 32 + view_ff();
        if (a >= 1 && a <= 3 && op != 0) begin
            mask = 0; opnd = 0;
            case (a)
                1: begin mask = 31;  opnd = csr_wdata_i % 32; end
                2: begin mask = 224; opnd = (csr_wdata_i % 8) * 32; end
                default: begin mask = 255; opnd = csr_wdata_i % 256; end
            endcase
            case (op)
                1:       new8 = (old8 & (255 - mask)) | opnd;
                2:       new8 = old8 | opnd;
                default: new8 = old8 & (255 - opnd);
            endcase
            m_frm = new8 / 32;
            m_ff  = new8 % 32;
            if (op == 1 || opnd != 0) set = 1;
        end
        if (fpu_valid_i) begin
            m_ff = m_ff | int'(fpu_fflags_i);
            if (fpu_fflags_i != 0) set = 1;
        end
        if (set) m_dirty = 1;
        else if (dirty_clr_i) m_dirty = 0;
    endtask

    task automatic cycle();
        #2;
        check("rdata", csr_rdata_o, exp_read());
        check("hit", {31'b0, csr_hit_o}, (csr_addr_i >= 1 && csr_addr_i <= 3) ? 1 : 0);
        check("rm", {29'b0, rm_o}, exp_rm());
        check("rm_illegal", {31'b0, rm_illegal_o}, (exp_rm() >= 5) ? 1 : 0);
        @(posedge clk);
        model_step();
        #1;
        check("fflags", {27'b0, fflags_o}, m_ff);
        check("frm", {29'b0, frm_o}, m_frm);
        check("dirty", {31'b0, dirty_o}, m_dirty);
    endtask

    initial begin
        vecs[0]  = '{2'd0, 12'h000, 32'h0,        1'b1, 5'b10000, 3'd7, 1'b0, 3'd0, 1'b0, 5'b10000, 3'd0, 1'b1};
        vecs[1]  = '{2'd0, 12'h000, 32'h0,        1'b1, 5'b00001, 3'd0, 1'b0, 3'd0, 1'b0, 5'b10001, 3'd0, 1'b1};
        vecs[2]  = '{2'd1, 12'h003, 32'hE5,       1'b0, 5'b00000, 3'd7, 1'b0, 3'd0, 1'b0, 5'b00101, 3'd7, 1'b1};
        vecs[3]  = '{2'd1, 12'h001, 32'h1F,       1'b0, 5'b00000, 3'd7, 1'b0, 3'd7, 1'b1, 5'b11111, 3'd7, 1'b1};
        vecs[4]  = '{2'd3, 12'h001, 32'h1F,       1'b1, 5'b00010, 3'd1, 1'b0, 3'd1, 1'b0, 5'b00010, 3'd7, 1'b1};
        vecs[5]  = '{2'd0, 12'h000, 32'h0,        1'b0, 5'b00000, 3'd0, 1'b1, 3'd0, 1'b0, 5'b00010, 3'd7, 1'b0};
        vecs[6]  = '{2'd1, 12'h002, 32'h3,        1'b0, 5'b00000, 3'd6, 1'b1, 3'd6, 1'b1, 5'b00010, 3'd3, 1'b1};
        vecs[7]  = '{2'd0, 12'h000, 32'h0,        1'b0, 5'b00000, 3'd0, 1'b1, 3'd0, 1'b0, 5'b00010, 3'd3, 1'b0};
        vecs[8]  = '{2'd2, 12'h002, 32'h0,        1'b0, 5'b00000, 3'd7, 1'b0, 3'd3, 1'b0, 5'b00010, 3'd3, 1'b0};
        vecs[9]  = '{2'd2, 12'h003, 32'hFFFFFF00, 1'b0, 5'b00000, 3'd5, 1'b0, 3'd5, 1'b1, 5'b00010, 3'd3, 1'b0};
        vecs[10] = '{2'd1, 12'h004, 32'hFF,       1'b0, 5'b00000, 3'd0, 1'b0, 3'd0, 1'b0, 5'b00010, 3'd3, 1'b0};
        vecs[11] = '{2'd3, 12'h003, 32'h62,       1'b0, 5'b00000, 3'd0, 1'b0, 3'd0, 1'b0, 5'b00000, 3'd0, 1'b1};
        vecs[12] = '{2'd0, 12'h000, 32'h0,        1'b1, 5'b00000, 3'd0, 1'b1, 3'd0, 1'b0, 5'b00000, 3'd0, 1'b0};
        vecs[13] = '{2'd1, 12'h002, 32'h5,        1'b0, 5'b00000, 3'd7, 1'b0, 3'd0, 1'b0, 5'b00000, 3'd5, 1'b1};
        vecs[14] = '{2'd2, 12'h001, 32'h0C,       1'b1, 5'b00001, 3'd7, 1'b1, 3'd5, 1'b1, 5'b01101, 3'd5, 1'b1};

        // Reset
        rst = 1'b1;
        drive(2'd0, 12'h003, 32'h0, 1'b0, 5'b0, 3'd7, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset_rdata_fcsr", csr_rdata_o, 32'h0);
        check("reset_rm_dyn", {29'b0, rm_o}, 32'h0);
        check("reset_dirty", {31'b0, dirty_o}, 32'h0);
        check("reset_fflags", {27'b0, fflags_o}, 32'h0);

        // Table vectors
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].fv, vecs[i].ff,
                  vecs[i].rm, vecs[i].clr);
            #1;
            check($sformatf("vec%0d_rm", i), {29'b0, rm_o}, {29'b0, vecs[i].exp_rm});
            check($sformatf("vec%0d_ill", i), {31'b0, rm_illegal_o}, {31'b0, vecs[i].exp_ill});
            cycle();
            check($sformatf("vec%0d_fflags", i), {27'b0, fflags_o}, {27'b0, vecs[i].exp_ff});
            check($sformatf("vec%0d_frm", i), {29'b0, frm_o}, {29'b0, vecs[i].exp_frm});
            check($sformatf("vec%0d_dirty", i), {31'b0, dirty_o}, {31'b0, vecs[i].exp_dirty});
        end

        // Reset dominates a same-cycle write, accumulation and dirty set
        rst = 1'b1;
        drive(2'd1, 12'h003, 32'hFF, 1'b1, 5'b11111, 3'd0, 1'b0);
        cycle();
        rst = 1'b0;
        check("midreset_fflags", {27'b0, fflags_o}, 32'h0);
        check("midreset_frm", {29'b0, frm_o}, 32'h0);
        check("midreset_dirty", {31'b0, dirty_o}, 32'h0);

        // Same-cycle read of a retiring op's flags
        drive(2'd0, 12'h001, 32'h0, 1'b1, 5'b01000, 3'd0, 1'b0);
        #1;
        check("bypass_same_cycle", csr_rdata_o, BYP ? 32'h8 : 32'h0);
        cycle();
        drive(2'd0, 12'h001, 32'h0, 1'b0, 5'b00000, 3'd0, 1'b0);
        #1;
        check("bypass_next_cycle", csr_rdata_o, 32'h8);
        cycle();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [11:0] a;
            case ($urandom_range(0, 4))
                0: a = 12'h001;
                1: a = 12'h002;
                2: a = 12'h003;
                3: a = 12'h000;
                default: a = 12'($urandom);
            endcase
            rst = ($urandom_range(0, 49) == 0);
            drive(2'($urandom), a, ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
                  1'($urandom), ($urandom_range(0, 2) == 0) ? 5'b0 : 5'($urandom),
                  3'($urandom), ($urandom_range(0, 3) == 0));
            cycle();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/core_fpu_fcsr.md
# core_fpu_fcsr

Floating-point control and status register (FCSR) for the RV32F core, sitting directly downstream of the single-precision FPU execution unit. Accumulates the FPU's per-operation exception flags (NV, DZ, OF, UF, NX) into sticky `fflags` and holds the `frm` rounding-mode field. Serves CSR reads and writes to `fflags` (0x001), `frm` (0x002) and `fcsr` (0x003). Resolves the instruction rounding-mode field, including dynamic mode `3'b111`, into the `frm` value the FPU consumes.

## Interface
Parameters: none.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `fpu_valid_i` input 1: an FPU instruction retires this cycle.
- `fpu_fflags_i` input 5: that instruction's flags, `{NV,DZ,OF,UF,NX}`.
- `instr_rm_i` input 3: rm field of the FP instruction in execute.
- `rm_o` output 3: resolved rounding mode, driven to the FPU `frm_i`.
- `rm_illegal_o` output 1: resolved rounding mode is reserved.
- `csr_op_i` input 2: `00` none, `01` RW, `10` RS (set), `11` RC (clear).
- `csr_addr_i` input 12: CSR address.
- `csr_wdata_i` input 32: CSR write operand.
- `csr_rdata_o` output 32: CSR read data.
- `csr_hit_o` output 1: `csr_addr_i` is 0x001, 0x002 or 0x003.
- `fflags_o` output 5: current sticky flags.
- `frm_o` output 3: current frm.
- `dirty_o` output 1: FP state modified since last clear; feeds mstatus.FS.
- `dirty_clr_i` input 1: clears `dirty_o`.

## Operation
- State: `fflags[4:0]`, `frm[2:0]`, `dirty`.
- Reset: all state 0. `frm` = RNE.
- Read (combinational, independent of `csr_op_i`):
  - 0x001 → `{27'b0,fflags}`
  - 0x002 → `{29'b0,frm}`
  - 0x003 → `{24'b0,frm,fflags}`
  - other addresses → 0 and `csr_hit_o`=0
- Write value per field: RW → operand; RS → old|operand; RC → old&~operand.
  - Operand bits: 0x001 uses `wdata[4:0]` for fflags. 0x002 uses `wdata[2:0]` for frm. 0x003 uses `[7:5]` for frm and `[4:0]` for fflags.
  - Fields not addressed are unchanged.
  - Bits `[31:8]` are ignored.
  - Non-hit addresses: no effect.
- `frm` stores any 3-bit value, including the reserved values 5–7. No write-time legalisation.
- Accumulate: if `fpu_valid_i`, `fflags_next = csr_result | fpu_fflags_i`.
  - `csr_result` is the CSR write result, or the old value if no fflags write occurs.
  - The retiring FPU op is treated as younger than the CSR op in the same cycle. An RC of all flags plus FPU NX in the same cycle leaves NX=1.
- Rounding resolve: `rm_o = (instr_rm_i==3'b111) ? frm : instr_rm_i`.
  - Uses registered `frm`; a same-cycle frm write is not forwarded.
  - `rm_illegal_o = rm_o ∈ {101,110,111}`.
- Dirty: `dirty` is set next cycle on either of:
  - any hit CSR op with `csr_op_i`≠00 that writes a field (RW always; RS/RC only if the relevant operand bits are nonzero);
  - `fpu_valid_i` with `fpu_fflags_i`≠0.
- Dirty clear: `dirty_clr_i` clears `dirty`. If a set condition occurs in the same cycle, set wins.
- Reset mid-operation: reset dominates all same-cycle writes, accumulation and dirty set.

## Timing
- Reads, `csr_hit_o`, `rm_o` and `rm_illegal_o`: zero latency, combinational.
- CSR writes and flag accumulation: visible on `fflags_o`/`frm_o`/`csr_rdata_o` one cycle after the edge.
- No handshake or stall: every cycle accepts one CSR op and one FPU retirement.

## Configuration
- `FCSR_READ_BYPASS_EN` defined:
  - When `fpu_valid_i`, the fflags field of `csr_rdata_o` is `fflags|fpu_fflags_i` (for 0x001 and 0x003).
  - RS/RC use this bypassed value as "old".
  - Result: a CSRR in the same cycle as an FPU retirement sees that retirement's flags.
- Not defined:
  - Reads and RS/RC use registered `fflags` only.
  - Same-cycle flags appear one cycle later.
  - The accumulate rule is unchanged.

## Test plan
- Reset, then read 0x003 → 0x00000000. `rm_o`=000 with `instr_rm_i`=111. `dirty_o`=0.
- Accumulation: `fpu_valid_i`=1 with flags 5'b10000 (NV), then 5'b00001 (NX) → `fflags_o`=5'b10001. `dirty_o`=1. Read 0x001 → 0x11.
- CSR write: RW 0x003 with 0x000000E5 → frm=111, fflags=00101. Then `instr_rm_i`=111 → `rm_o`=111, `rm_illegal_o`=1. `instr_rm_i`=001 → `rm_o`=001, `rm_illegal_o`=0.
- Simultaneous events: fflags=11111, RC 0x001 with 0x1F, plus `fpu_valid_i` with 00010 in the same cycle → `fflags_o`=00010.
- Set/clear priority: `dirty_clr_i`=1 alone → `dirty_o`=0. `dirty_clr_i`=1 with RW 0x002 wdata 0x3 → `dirty_o`=1, frm=011. RS 0x002 with wdata 0 → no dirty set.
- Bypass: fflags=0, `fpu_valid_i` with 01000 and read 0x001 in the same cycle → rdata 0x08 with `FCSR_READ_BYPASS_EN`, 0x00 without. Both builds: 0x08 next cycle.
